sync_bus_filter: RTL and testbench
==================================

// Module: sync_bus_filter
// PURPOSE
//   Parametrised multi-channel synchroniser: brings WIDTH independent asynchronous inputs into the clk domain.
//   Uses a STAGES-deep flop chain per channel and produces registered level, rise and fall pulses, plus sticky
//   event flags. It replaces single-bit two-flop meta flops for buttons, status pins and slow cross-domain flags.
// PARAMETERS
//   WIDTH            4    number of independent channels
//   STAGES           2    synchroniser depth incl. output flop; legal range >=2
//   RESET_VAL        '0   WIDTH-bit value loaded into every stage and q on reset
//   DEBOUNCE_CYCLES  16   stable cycles required before q changes; used only with SYNC_DEBOUNCE_EN; >=1
// PORTS
//   clk       in   1      single clock; all state on posedge clk
//   reset     in   1      asynchronous, active-high reset
//   d         in   WIDTH  asynchronous inputs; no timing relation to clk
//   clear     in   1      sync; clears all sticky flags
//   q         out  WIDTH  synchronised (optionally debounced) level, registered
//   rise      out  WIDTH  1-cycle pulse, registered, coincident with q 0->1
//   fall      out  WIDTH  1-cycle pulse, registered, coincident with q 1->0
//   sticky    out  WIDTH  per-channel flag set by rise|fall, held until clear
//   changed   out  1      registered OR-reduce of (rise|fall) for the same cycle
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): sync stages=RESET_VAL, q=RESET_VAL, rise=fall=0,
//     sticky=0, changed=0, debounce counters=0. No pulses are generated on reset release.
//   - Chain per channel: s[0]<=d, s[i]<=s[i-1], i=1..STAGES-2. Comparison sample smp=s[STAGES-2]; q is the last stage.
//   - Channels are fully independent; no cross-channel coherency guaranteed (not for bus values).
//   - Without debounce: q<=smp; rise<=smp&~q; fall<=~smp&q (same edge). Latency: d stable before
//     edge 1 -> q/rise/fall updated at edge STAGES.
//   - sticky<=clear ? (rise_next|fall_next) : (sticky|rise_next|fall_next); simultaneous set+clear -> set wins.
//     Here rise_next/fall_next are the values being loaded into rise/fall on that edge.
//   - changed<=|(rise_next|fall_next); same edge as rise/fall.
//   - Mid-operation reset: all in-flight samples and counters discarded; same state as power-up reset.
//   - Input toggling every cycle: q tracks smp exactly (no debounce); rise/fall alternate, never both set.
// CONFIGURATION
//   SYNC_DEBOUNCE_EN defined: per-channel counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
//     Counter and q update per edge:
//       smp==q                         -> cnt<=0, q held
//       smp!=q, cnt<DEBOUNCE_CYCLES-1  -> cnt<=cnt+1, q held
//       smp!=q, cnt==DEBOUNCE_CYCLES-1 -> q<=smp, cnt<=0, rise/fall pulse
//     Latency: STAGES-1+DEBOUNCE_CYCLES edges. Glitch visible at smp for <DEBOUNCE_CYCLES cycles never reaches q.
//     Counter never wraps.
//   SYNC_DEBOUNCE_EN undefined: no counters, DEBOUNCE_CYCLES ignored; behaviour as "Without debounce".
// TESTING
//   1 WIDTH=4,STAGES=2,RESET_VAL=4'b0101: assert reset with d=4'b1111 -> q=4'b0101, no pulse on release.
//   2 no debounce, STAGES=3: d[0] 0->1 before edge 1 -> q[0]=1, rise[0]=1, changed=1 at edge 3;
//     rise[0]=0 at edge 4.
//   3 SYNC_DEBOUNCE_EN, DEBOUNCE_CYCLES=4, STAGES=2: d[1] high 3 cycles -> q[1] stays 0, no pulse;
//     high 4+ cycles -> q[1]=1 at edge 5.
//   4 rise[2] and clear on same edge -> sticky[2]=1; clear alone next edge -> sticky=0.
//   5 reset asserted mid-debounce (cnt=2) -> cnt=0, q=RESET_VAL immediately without clk; no fall pulse.
//   6 random async d on all channels, 10k cycles -> q equals reference model delayed STAGES; rise&fall never both 1.

Source files
------------

// File: rtl/sync_bus_filter.sv
// -----------------------------------------------------------------------------
// sync_bus_filter
//   Multi-channel synchroniser for WIDTH independent asynchronous inputs.
//   Each channel passes through a STAGES-deep flop chain (the last flop is q).
//   The block produces a registered level (q), one-cycle rise/fall pulses that
//   coincide with q changing, per-channel sticky event flags and a combined
//   "changed" flag. Channels are independent, so this block is not suitable
//   for multi-bit bus values that must stay coherent.
//
//   Optional feature (compile-time macro SYNC_DEBOUNCE_EN):
//     When the macro is defined, each channel has a debounce counter. q only follows
//     the synchronised sample after it has differed from q for DEBOUNCE_CYCLES
//     consecutive edges. When the macro is undefined, q follows the sample directly.
//
// Parameters
//   WIDTH            number of channels
//   STAGES           synchroniser depth including the q flop (>= 2)
//   RESET_VAL        value loaded into every stage and q on reset
//   DEBOUNCE_CYCLES  stable edges required before q changes (debounce build only, >= 1)
//
// Ports
//   clk      in   1      clock; all state updates on posedge
//   reset    in   1      asynchronous, active-high reset
//   d        in   WIDTH  asynchronous inputs
//   clear    in   1      synchronous clear of the sticky flags
//   q        out  WIDTH  synchronised (optionally debounced) level
//   rise     out  WIDTH  one-cycle pulse when q goes 0->1
//   fall     out  WIDTH  one-cycle pulse when q goes 1->0
//   sticky   out  WIDTH  set by rise|fall, held until clear (set wins)
//   changed  out  1      OR of all rise|fall bits, same cycle as the pulses
// -----------------------------------------------------------------------------
module sync_bus_filter #(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = 2,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] sticky,
  output logic             changed
);

  // Elaboration-time guard against illegal configurations.
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bus_filter: STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("sync_bus_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  // Synchroniser chain ahead of q. The last entry is the comparison sample.
  logic [WIDTH-1:0] r_sync [STAGES-1];
  logic [WIDTH-1:0] w_smp;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_sticky;
  logic             r_changed;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic [WIDTH-1:0] w_event_next;

  assign w_smp = r_sync[STAGES-2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  // NOTE: the chain is an array of flops, not a RAM, so resetting every entry is
  // cheap and required to keep in-flight samples from surviving a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        r_sync[i] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= d;
      for (int i = 1; i < STAGES - 1; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

`ifdef SYNC_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt      [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];

  // The counter restarts whenever the sample agrees with q, so a glitch shorter
  // than DEBOUNCE_CYCLES is forgotten; it commits at CNT_LAST and never wraps.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_smp[i] == r_q[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_q_next[i]   = w_smp[i];
        w_cnt_next[i] = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  always_comb begin
    w_q_next = w_smp;
  end
`endif

  // Pulses are derived from the value q is about to take, so they line up with
  // the q transition and reset release cannot create one (q and sample match).
  assign w_rise_next  = w_q_next & ~r_q;
  assign w_fall_next  = ~w_q_next & r_q;
  assign w_event_next = w_rise_next | w_fall_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= RESET_VAL;
      r_rise    <= '0;
      r_fall    <= '0;
      r_sticky  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_rise    <= w_rise_next;
      r_fall    <= w_fall_next;
      // A new event on the clearing edge survives the clear.
      r_sticky  <= clear ? w_event_next : (r_sticky | w_event_next);
      r_changed <= |w_event_next;
    end
  end

  assign q       = r_q;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign sticky  = r_sticky;
  assign changed = r_changed;

endmodule

// File: tb/tb_sync_bus_filter.sv
module tb_sync_bus_filter;

  localparam int         WIDTH   = 4;
  localparam int         STAGES  = 3;
  localparam int         DEB     = 4;
  localparam logic [3:0] RST_VAL = 4'b0101;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] sticky;
  logic       changed;

  always #5 clk = ~clk;

  sync_bus_filter #(
    .WIDTH          (WIDTH),
    .STAGES         (STAGES),
    .RESET_VAL      (RST_VAL),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .d      (d),
    .clear  (clear),
    .q      (q),
    .rise   (rise),
    .fall   (fall),
    .sticky (sticky),
    .changed(changed)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The input path is a pure delay of STAGES-1 edges before the value q compares
  // against; a queue holds those in-flight samples.
  logic [3:0] m_pipe[$];
  logic [3:0] m_q, m_rise, m_fall, m_sticky;
  logic       m_changed;
  int         m_cnt[WIDTH];

  function automatic void model_reset();
    m_pipe = {};
    for (int i = 0; i < STAGES - 1; i++) m_pipe.push_back(RST_VAL);
    m_q = RST_VAL; m_rise = '0; m_fall = '0; m_sticky = '0; m_changed = 1'b0;
    for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] din, input logic clr);
    logic [3:0] smp, nq, ev;
    smp = m_pipe.pop_front();
    m_pipe.push_back(din);
`ifdef SYNC_DEBOUNCE_EN
    nq = m_q;
    for (int ch = 0; ch < WIDTH; ch++) begin
      if (smp[ch] == m_q[ch]) m_cnt[ch] = 0;
      else if (m_cnt[ch] < DEB - 1) m_cnt[ch] = m_cnt[ch] + 1;
      else begin nq[ch] = smp[ch]; m_cnt[ch] = 0; end
    end
`else
    nq = smp;
`endif
    m_rise    = nq & ~m_q;
    m_fall    = ~nq & m_q;
    ev        = m_rise | m_fall;
    m_sticky  = clr ? ev : (m_sticky | ev);
    m_changed = |ev;
    m_q       = nq;
  endfunction

  // One clock edge: the model consumes the inputs present at the edge, outputs
  // are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge(d, clear);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},       q,       m_q);
    check({tag, ".rise"},    rise,    m_rise);
    check({tag, ".fall"},    fall,    m_fall);
    check({tag, ".sticky"},  sticky,  m_sticky);
    check({tag, ".changed"}, changed, m_changed);
    check({tag, ".excl"},    rise & fall, 0);
  endtask

  // Assert reset between edges (we are at posedge+1), check the async effect,
  // then release before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #2;
    check({tag, ".rst_q"},       q,       RST_VAL);
    check({tag, ".rst_rise"},    rise,    0);
    check({tag, ".rst_fall"},    fall,    0);
    check({tag, ".rst_sticky"},  sticky,  0);
    check({tag, ".rst_changed"}, changed, 0);
    #1;
    reset = 1'b0;
  endtask

`ifndef SYNC_DEBOUNCE_EN
  typedef struct {
    logic [3:0] d;
    logic       clear;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] sticky;
    logic       changed;
  } vec_t;
  vec_t vecs[15];
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_edges;
    bit seen;

    reset = 1'b1; clear = 1'b0; d = 4'b1111;
    model_reset();

    // Reset with all inputs high: q must show RESET_VAL, no pulse on release.
    #12;
    check("por.q",      q,      RST_VAL);
    check("por.rise",   rise,   0);
    check("por.fall",   fall,   0);
    check("por.sticky", sticky, 0);
    check("por.changed", changed, 0);
    #1 reset = 1'b0;
    tick();
    check("release.rise", rise, 0);
    check("release.fall", fall, 0);
    check_model("release1");
    tick();
    check_model("release2");
    tick();
    check_model("release3");

`ifndef SYNC_DEBOUNCE_EN
    // Hand-derived vectors for STAGES=3, starting from reset (q=0101).
    vecs[0]  = '{4'b0101, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0111, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0111, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0111, 1'b0, 4'b0111, 4'b0010, 4'b0000, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0111, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vecs[5]  = '{4'b0110, 1'b1, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0110, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{4'b1110, 1'b0, 4'b0110, 4'b0000, 4'b0001, 4'b0001, 1'b1};
    vecs[8]  = '{4'b1110, 1'b0, 4'b0110, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    vecs[9]  = '{4'b1110, 1'b1, 4'b1110, 4'b1000, 4'b0000, 4'b1000, 1'b1};
    vecs[10] = '{4'b1110, 1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[11] = '{4'b0001, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{4'b0001, 1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[13] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b1110, 4'b1111, 1'b1};
    vecs[14] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    do_reset("table");
    for (int i = 0; i < 15; i++) begin
      d = vecs[i].d; clear = vecs[i].clear;
      tick();
      check($sformatf("row%0d.q", i),       q,       vecs[i].q);
      check($sformatf("row%0d.rise", i),    rise,    vecs[i].rise);
      check($sformatf("row%0d.fall", i),    fall,    vecs[i].fall);
      check($sformatf("row%0d.sticky", i),  sticky,  vecs[i].sticky);
      check($sformatf("row%0d.changed", i), changed, vecs[i].changed);
    end
    clear = 1'b0;
`endif

    // Toggle every input every cycle.
    do_reset("toggle");
    d = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_model($sformatf("toggle%0d", i));
      d = ~d;
    end

    // Reset in the middle of activity: pending samples and counters discarded.
    do_reset("mid_pre");
    d = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model($sformatf("mid%0d", i));
    end
    do_reset("mid");
    d = RST_VAL;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_model($sformatf("mid_after%0d", i));
      check($sformatf("mid_after%0d.no_pulse", i), rise | fall, 0);
    end

`ifdef SYNC_DEBOUNCE_EN
    // A 3-cycle pulse on d[1] must be filtered out entirely.
    do_reset("deb");
    d = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_model($sformatf("glitch%0d", i));
    end
    d = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_model($sformatf("glitch_tail%0d", i));
      check($sformatf("glitch_tail%0d.q1", i), q[1], 1'b0);
      check($sformatf("glitch_tail%0d.pulse", i), rise | fall, 0);
    end
    // A held level reaches q after STAGES-1+DEB edges.
    d = 4'b0111;
    n_edges = 0;
    seen = 1'b0;
    while (!seen && n_edges < 20) begin
      tick();
      n_edges++;
      check_model($sformatf("deb_hold%0d", n_edges));
      seen = q[1];
    end
    check("deb.latency", n_edges, STAGES - 1 + DEB);
    check("deb.rise", rise, 4'b0010);
`endif

    // Random stimulus: sparse per-bit flips plus occasional full scrambles.
    do_reset("rand");
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 31) == 0) d = 4'($urandom);
      else begin
        for (int b = 0; b < WIDTH; b++)
          if ($urandom_range(0, 7) == 0) d[b] = ~d[b];
      end
      clear = ($urandom_range(0, 15) == 0);
      tick();
      check_model("rand");
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
